// File: rtl/debug_dump_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debug_dump_sequencer_pkg                                             |
// | Shared widths and defaults for the snapshot-to-UART dump path.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package debug_dump_sequencer_pkg;

  localparam int DFLT_UART_BITS       = 8;
  localparam int DFLT_PROC_BITS       = 32;
  localparam int DFLT_RF_REGS_LEN     = 1024;
  localparam int DFLT_IF_ID_LEN       = 64;
  localparam int DFLT_ID_EX_LEN       = 144;
  localparam int DFLT_EX_MEM_LEN      = 80;
  localparam int DFLT_MEM_WB_LEN      = 72;
  localparam int DFLT_DATA_ADDRS_BITS = 7;
  localparam int DFLT_DATA_WORDS      = 32;

  typedef enum logic [2:0] {
    SEG_RF     = 3'd0,
    SEG_IF_ID  = 3'd1,
    SEG_ID_EX  = 3'd2,
    SEG_EX_MEM = 3'd3,
    SEG_MEM_WB = 3'd4
  } seg_e;

endpackage
`default_nettype wire

// File: rtl/debug_byte_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debug_byte_select                                                    |
// | Maps (segment, byte index) to a snapshot byte plus last-byte flag.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module debug_byte_select
  import debug_dump_sequencer_pkg::*;
#(
  parameter int UART_BITS   = DFLT_UART_BITS,
  parameter int PROC_BITS   = DFLT_PROC_BITS,
  parameter int RF_REGS_LEN = DFLT_RF_REGS_LEN,
  parameter int IF_ID_LEN   = DFLT_IF_ID_LEN,
  parameter int ID_EX_LEN   = DFLT_ID_EX_LEN,
  parameter int EX_MEM_LEN  = DFLT_EX_MEM_LEN,
  parameter int MEM_WB_LEN  = DFLT_MEM_WB_LEN,
  parameter int IDX_BITS    = 9
) (
  input  seg_e                   i_seg,
  input  logic [IDX_BITS-1:0]    i_byte_idx,
  input  logic [RF_REGS_LEN-1:0] i_rf_regs,
  input  logic [IF_ID_LEN-1:0]   i_if_id_signals,
  input  logic [ID_EX_LEN-1:0]   i_id_ex_signals,
  input  logic [EX_MEM_LEN-1:0]  i_ex_mem_signals,
  input  logic [MEM_WB_LEN-1:0]  i_mem_wb_signals,
  output logic [UART_BITS-1:0]   o_byte,
  output logic                   o_last
);

  localparam int REG_BYTES    = PROC_BITS / UART_BITS;
  localparam int RF_BYTES     = RF_REGS_LEN / UART_BITS;
  localparam int IF_ID_BYTES  = IF_ID_LEN / UART_BITS;
  localparam int ID_EX_BYTES  = ID_EX_LEN / UART_BITS;
  localparam int EX_MEM_BYTES = EX_MEM_LEN / UART_BITS;
  localparam int MEM_WB_BYTES = MEM_WB_LEN / UART_BITS;

  int idx;
  int reg_n;
  int sub;

  // Register file goes reg0 first, yet each register is sent MSB byte first.
  always_comb begin
    o_byte = '0;
    o_last = 1'b0;
    idx    = int'(i_byte_idx);
    reg_n  = idx / REG_BYTES;
    sub    = idx % REG_BYTES;
    case (i_seg)
      SEG_RF: if (idx < RF_BYTES) begin
        o_byte = i_rf_regs[reg_n*PROC_BITS + (REG_BYTES-1-sub)*UART_BITS +: UART_BITS];
        o_last = (idx == RF_BYTES-1);
      end
      SEG_IF_ID: if (idx < IF_ID_BYTES) begin
        o_byte = i_if_id_signals[IF_ID_LEN - (idx+1)*UART_BITS +: UART_BITS];
        o_last = (idx == IF_ID_BYTES-1);
      end
      SEG_ID_EX: if (idx < ID_EX_BYTES) begin
        o_byte = i_id_ex_signals[ID_EX_LEN - (idx+1)*UART_BITS +: UART_BITS];
        o_last = (idx == ID_EX_BYTES-1);
      end
      SEG_EX_MEM: if (idx < EX_MEM_BYTES) begin
        o_byte = i_ex_mem_signals[EX_MEM_LEN - (idx+1)*UART_BITS +: UART_BITS];
        o_last = (idx == EX_MEM_BYTES-1);
      end
      SEG_MEM_WB: if (idx < MEM_WB_BYTES) begin
        o_byte = i_mem_wb_signals[MEM_WB_LEN - (idx+1)*UART_BITS +: UART_BITS];
        o_last = (idx == MEM_WB_BYTES-1);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/debug_dump_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debug_dump_sequencer                                                 |
// | Streams a frozen processor snapshot and data memory out over UART.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int UART_BITS       = DFLT_UART_BITS,
  parameter int PROC_BITS       = DFLT_PROC_BITS,
  parameter int RF_REGS_LEN     = DFLT_RF_REGS_LEN,
  parameter int IF_ID_LEN       = DFLT_IF_ID_LEN,
  parameter int ID_EX_LEN       = DFLT_ID_EX_LEN,
  parameter int EX_MEM_LEN      = DFLT_EX_MEM_LEN,
  parameter int MEM_WB_LEN      = DFLT_MEM_WB_LEN,
  parameter int DATA_ADDRS_BITS = DFLT_DATA_ADDRS_BITS,
  parameter int DATA_WORDS      = DFLT_DATA_WORDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [RF_REGS_LEN-1:0]     i_rf_regs,
  input  logic [IF_ID_LEN-1:0]       i_if_id_signals,
  input  logic [ID_EX_LEN-1:0]       i_id_ex_signals,
  input  logic [EX_MEM_LEN-1:0]      i_ex_mem_signals,
  input  logic [MEM_WB_LEN-1:0]      i_mem_wb_signals,
  input  logic [PROC_BITS-1:0]       i_mem_data,
  input  logic                       i_tx_done,
  output logic                       o_debug_read_data,
  output logic [DATA_ADDRS_BITS-1:0] o_debug_read_address,
  output logic                       o_tx_start,
  output logic [UART_BITS-1:0]       o_tx_data,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_WAIT_TX  = 3'd2,
    S_MEM_REQ  = 3'd3,
    S_MEM_CAP  = 3'd4,
    S_MEM_LOAD = 3'd5,
    S_MEM_WAIT = 3'd6,
    S_FIN      = 3'd7
  } state_e;

  localparam int   NUM_SEGS   = 5;
  localparam seg_e LAST_SEG   = seg_e'(NUM_SEGS-1);
  localparam int   IDX_BITS   =
    $clog2((RF_REGS_LEN+IF_ID_LEN+ID_EX_LEN+EX_MEM_LEN+MEM_WB_LEN)/UART_BITS) + 1;
  localparam int   WORD_BYTES = PROC_BITS / UART_BITS;
  localparam int   CNT_BITS   = $clog2(WORD_BYTES+1);
  localparam logic [CNT_BITS-1:0]        LAST_CNT  = CNT_BITS'(WORD_BYTES-1);
  localparam logic [DATA_ADDRS_BITS-1:0] LAST_ADDR = DATA_ADDRS_BITS'(DATA_WORDS-1);

  state_e                     state_q, state_d;
  seg_e                       seg_q, seg_d;
  logic [IDX_BITS-1:0]        byte_idx_q, byte_idx_d;
  logic [DATA_ADDRS_BITS-1:0] word_addr_q, word_addr_d;
  logic [PROC_BITS-1:0]       shift_q, shift_d;
  logic [CNT_BITS-1:0]        byte_cnt_q, byte_cnt_d;
  logic [UART_BITS-1:0]       tx_data_q, tx_data_d;
  logic                       tx_start_q, tx_start_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [UART_BITS-1:0]       sel_byte;
  logic                       sel_last;

  debug_byte_select #(
    .UART_BITS  (UART_BITS),
    .PROC_BITS  (PROC_BITS),
    .RF_REGS_LEN(RF_REGS_LEN),
    .IF_ID_LEN  (IF_ID_LEN),
    .ID_EX_LEN  (ID_EX_LEN),
    .EX_MEM_LEN (EX_MEM_LEN),
    .MEM_WB_LEN (MEM_WB_LEN),
    .IDX_BITS   (IDX_BITS)
  ) u_byte_select (
    .i_seg           (seg_q),
    .i_byte_idx      (byte_idx_q),
    .i_rf_regs       (i_rf_regs),
    .i_if_id_signals (i_if_id_signals),
    .i_id_ex_signals (i_id_ex_signals),
    .i_ex_mem_signals(i_ex_mem_signals),
    .i_mem_wb_signals(i_mem_wb_signals),
    .o_byte          (sel_byte),
    .o_last          (sel_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      seg_q       <= SEG_RF;
      byte_idx_q  <= '0;
      word_addr_q <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      byte_idx_q  <= byte_idx_d;
      word_addr_q <= word_addr_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    byte_idx_d  = byte_idx_q;
    word_addr_d = word_addr_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) begin
        busy_d     = 1'b1;
        seg_d      = SEG_RF;
        byte_idx_d = '0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        tx_data_d  = sel_byte;
        tx_start_d = 1'b1;
        state_d    = S_WAIT_TX;
      end
      S_WAIT_TX: if (i_tx_done) begin
        if (!sel_last) begin
          byte_idx_d = byte_idx_q + IDX_BITS'(1);
          state_d    = S_LOAD;
        end else if (seg_q != LAST_SEG) begin
          seg_d      = seg_e'(seg_q + 3'd1);
          byte_idx_d = '0;
          state_d    = S_LOAD;
        end else begin
          word_addr_d = '0;
          state_d     = S_MEM_REQ;
        end
      end
      S_MEM_REQ: state_d = S_MEM_CAP;
      S_MEM_CAP: begin
        shift_d    = i_mem_data;
        byte_cnt_d = '0;
        state_d    = S_MEM_LOAD;
      end
      S_MEM_LOAD: begin
        tx_data_d  = shift_q[PROC_BITS-1 -: UART_BITS];
        tx_start_d = 1'b1;
        state_d    = S_MEM_WAIT;
      end
      // Compare before incrementing so a full 2^N address space never wraps.
      S_MEM_WAIT: if (i_tx_done) begin
        shift_d = shift_q << UART_BITS;
        if (byte_cnt_q != LAST_CNT) begin
          byte_cnt_d = byte_cnt_q + CNT_BITS'(1);
          state_d    = S_MEM_LOAD;
        end else if (word_addr_q == LAST_ADDR) begin
          state_d = S_FIN;
        end else begin
          word_addr_d = word_addr_q + DATA_ADDRS_BITS'(1);
          state_d     = S_MEM_REQ;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_debug_read_data    = (state_q == S_MEM_REQ);
  assign o_debug_read_address = o_debug_read_data ? word_addr_q : '0;
  assign o_tx_start           = tx_start_q;
  assign o_tx_data            = tx_data_q;
  assign o_busy               = busy_q;
  assign o_done               = done_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_dump_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_debug_dump_sequencer                                              |
// | Directed bench: default build plus a 128-word build side by side.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_debug_dump_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [1023:0] rf;
  logic [63:0]   if_id;
  logic [143:0]  id_ex;
  logic [79:0]   ex_mem;
  logic [71:0]   mem_wb;

  logic [1:0][31:0] mem_data;
  logic [1:0]       tx_done;
  logic [1:0]       rd;
  logic [1:0][6:0]  rd_addr;
  logic [1:0]       tx_start;
  logic [1:0][7:0]  tx_data;
  logic [1:0]       busy;
  logic [1:0]       done;

  logic [1:0] model_done   = 2'b00;
  logic [1:0] model_done_d = 2'b00;
  int         model_cnt [2] = '{0, 0};
  logic       stretch;
  logic       inject_done;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         start_cnt [2];
  int         done_cnt [2];
  int         rd_cnt [2];
  int         exp_addr [2];
  int         last_addr [2];
  int         last_done_cyc [2];
  logic       outstanding [2];
  logic       prev_rd [2];
  logic [7:0] held [2];
  logic [7:0] blog [2][1024];

  debug_dump_sequencer u_dut (
    .clk(clk), .rst(rst), .i_start(start),
    .i_rf_regs(rf), .i_if_id_signals(if_id), .i_id_ex_signals(id_ex),
    .i_ex_mem_signals(ex_mem), .i_mem_wb_signals(mem_wb),
    .i_mem_data(mem_data[0]), .i_tx_done(tx_done[0]),
    .o_debug_read_data(rd[0]), .o_debug_read_address(rd_addr[0]),
    .o_tx_start(tx_start[0]), .o_tx_data(tx_data[0]),
    .o_busy(busy[0]), .o_done(done[0])
  );

  debug_dump_sequencer #(.DATA_WORDS(128)) u_dut128 (
    .clk(clk), .rst(rst), .i_start(start),
    .i_rf_regs(rf), .i_if_id_signals(if_id), .i_id_ex_signals(id_ex),
    .i_ex_mem_signals(ex_mem), .i_mem_wb_signals(mem_wb),
    .i_mem_data(mem_data[1]), .i_tx_done(tx_done[1]),
    .o_debug_read_data(rd[1]), .o_debug_read_address(rd_addr[1]),
    .o_tx_start(tx_start[1]), .o_tx_data(tx_data[1]),
    .o_busy(busy[1]), .o_done(done[1])
  );

  assign tx_done[0] = model_done[0] | (stretch & model_done_d[0]) | inject_done;
  assign tx_done[1] = model_done[1] | (stretch & model_done_d[1]) | inject_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART answers 10 cycles after each start and keeps running through rst;
  // memory returns word n = C0DE0000+n one cycle after the read strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      model_done[i]   <= 1'b0;
      model_done_d[i] <= model_done[i];
      if (tx_start[i]) model_cnt[i] <= 10;
      else if (model_cnt[i] != 0) begin
        model_cnt[i] <= model_cnt[i] - 1;
        if (model_cnt[i] == 1) model_done[i] <= 1'b1;
      end
      if (rd[i]) mem_data[i] <= 32'hC0DE_0000 + 32'(rd_addr[i]);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        outstanding[i] = 1'b0;
        prev_rd[i]     = 1'b0;
      end else begin
        if (tx_done[i] && outstanding[i]) begin
          outstanding[i]   = 1'b0;
          last_done_cyc[i] = cyc;
        end
        if (tx_start[i]) begin
          check("overlap", 32'(outstanding[i]), 32'd0);
          if (start_cnt[i] < 1024) blog[i][start_cnt[i]] = tx_data[i];
          start_cnt[i]++;
          outstanding[i] = 1'b1;
          held[i]        = tx_data[i];
        end else if (outstanding[i]) begin
          check("tx_data_hold", 32'(tx_data[i]), 32'(held[i]));
        end
        if (rd[i]) begin
          check("rd_width", 32'(prev_rd[i]), 32'd0);
          check("rd_addr", 32'(rd_addr[i]), 32'(exp_addr[i]));
          exp_addr[i]++;
          rd_cnt[i]++;
          last_addr[i] = int'(rd_addr[i]);
        end
        prev_rd[i] = rd[i];
        if (done[i]) begin
          done_cnt[i]++;
          check("done_latency", 32'(cyc - last_done_cyc[i]), 32'd2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      start_cnt[i]     = 0;
      done_cnt[i]      = 0;
      rd_cnt[i]        = 0;
      exp_addr[i]      = 0;
      last_addr[i]     = -1;
      last_done_cyc[i] = 0;
      outstanding[i]   = 1'b0;
      prev_rd[i]       = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!(done_cnt[0] >= 1 && done_cnt[1] >= 1) && n < bound) begin
      step();
      n++;
    end
    check("dump_timeout", 32'(n >= bound), 32'd0);
    repeat (5) step();
  endtask

  task automatic check_full_dump(input string tag);
    check({tag, "_starts"},     32'(start_cnt[0]), 32'd301);
    check({tag, "_dones"},      32'(done_cnt[0]),  32'd1);
    check({tag, "_reads"},      32'(rd_cnt[0]),    32'd32);
    check({tag, "_byte0"},      32'(blog[0][0]),   32'hA0);
    check({tag, "_byte300"},    32'(blog[0][300]), 32'h1F);
    check({tag, "_w128_starts"}, 32'(start_cnt[1]), 32'd685);
    check({tag, "_w128_reads"},  32'(rd_cnt[1]),    32'd128);
    check({tag, "_w128_last"},   32'(last_addr[1]), 32'd127);
    check({tag, "_w128_b684"},   32'(blog[1][684]), 32'h7F);
    check({tag, "_busy_end"},    32'(busy),         32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stretch = 1'b0; inject_done = 1'b0;
    for (int k = 0; k < 32; k++) rf[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    if_id = 64'h0011_2233_4455_6677;
    for (int b = 0; b < 18; b++) id_ex[143-8*b -: 8] = 8'(8'h10 + b);
    for (int b = 0; b < 10; b++) ex_mem[79-8*b -: 8] = 8'(8'h30 + b);
    for (int b = 0; b < 9; b++)  mem_wb[71-8*b -: 8] = 8'(8'h40 + b);
    clear_counts();

    // Reset, then idle.
    repeat (3) step();
    check("rst_busy",     32'(busy[0]),     32'd0);
    check("rst_tx_start", 32'(tx_start[0]), 32'd0);
    check("rst_tx_data",  32'(tx_data[0]),  32'd0);
    check("rst_done",     32'(done[0]),     32'd0);
    check("rst_rd",       32'(rd[0]),       32'd0);
    check("rst_rd_addr",  32'(rd_addr[0]),  32'd0);
    rst = 1'b0;
    repeat (20) step();
    check("idle_starts",  32'(start_cnt[0] + start_cnt[1]), 32'd0);
    check("idle_outputs", {busy, tx_start, done, rd, tx_data[0]}, 32'd0);

    // Full dump with a clean UART.
    pulse_start();
    check("lat_busy",   32'(busy[0]),     32'd1);
    check("lat_cycle1", 32'(tx_start[0]), 32'd0);
    step();
    check("lat_cycle2", 32'(tx_start[0]), 32'd1);
    check("lat_byte0",  32'(tx_data[0]),  32'hA0);
    wait_done(12000);
    check_full_dump("run1");
    check("b1",   32'(blog[0][1]),   32'h00);
    check("b2",   32'(blog[0][2]),   32'h00);
    check("b3",   32'(blog[0][3]),   32'h00);
    check("b7",   32'(blog[0][7]),   32'h01);
    check("b127", 32'(blog[0][127]), 32'h1F);
    check("b128", 32'(blog[0][128]), 32'h00);
    check("b129", 32'(blog[0][129]), 32'h11);
    check("b135", 32'(blog[0][135]), 32'h77);
    check("b136", 32'(blog[0][136]), 32'h10);
    check("b153", 32'(blog[0][153]), 32'h21);
    check("b154", 32'(blog[0][154]), 32'h30);
    check("b163", 32'(blog[0][163]), 32'h39);
    check("b164", 32'(blog[0][164]), 32'h40);
    check("b172", 32'(blog[0][172]), 32'h48);
    check("b173", 32'(blog[0][173]), 32'hC0);
    check("b174", 32'(blog[0][174]), 32'hDE);
    check("b175", 32'(blog[0][175]), 32'h00);
    check("b176", 32'(blog[0][176]), 32'h00);
    check("b180", 32'(blog[0][180]), 32'h01);
    check("w128_b173", 32'(blog[1][173]), 32'hC0);
    check("w128_b681", 32'(blog[1][681]), 32'hC0);
    check("w128_b682", 32'(blog[1][682]), 32'hDE);
    check("w128_b683", 32'(blog[1][683]), 32'h00);

    // Stretched done pulses land in LOAD-type states; extra starts while busy.
    clear_counts();
    stretch = 1'b1;
    inject_done = 1'b1;
    pulse_start();
    inject_done = 1'b0;
    check("hs_start_taken", 32'(busy[0]), 32'd1);
    repeat (200) step();
    pulse_start();
    repeat (1500) step();
    pulse_start();
    wait_done(12000);
    stretch = 1'b0;
    check_full_dump("run2");

    // Reset after byte 50 has started.
    clear_counts();
    pulse_start();
    begin
      int n = 0;
      while (start_cnt[0] < 51 && n < 2000) begin
        step();
        n++;
      end
      check("b50_timeout", 32'(n >= 2000), 32'd0);
    end
    rst = 1'b1;
    step();
    check("mid_rst_busy",     32'(busy[0]),     32'd0);
    check("mid_rst_tx_start", 32'(tx_start[0]), 32'd0);
    check("mid_rst_tx_data",  32'(tx_data[0]),  32'd0);
    rst = 1'b0;
    repeat (15) step();
    check("late_done_starts", 32'(start_cnt[0]), 32'd51);
    check("late_done_busy",   32'(busy[0]),      32'd0);
    clear_counts();
    pulse_start();
    wait_done(12000);
    check_full_dump("run3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
